neuron_layer_scheduler: RTL and testbench

Time-multiplexes one single-neuron datapath/controller pair across all NUM_NEURONS neurons of a fully connected layer. On a layer start it latches the 64-bit layer input vector, then for each neuron index it presents the index to the external weight/bias store, pulses the neuron's start, waits for the neuron's finish, and writes the 8-bit result to the layer output buffer. It sits between the network top-level sequencer and one neuron instance, and adds a finish-timeout watchdog.

---
 rtl/neuron_layer_scheduler.sv | 168 ++++++++++++++++
 tb/tb_neuron_layer_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_scheduler.sv
// neuron_layer_scheduler
//   Time-multiplexes one single-neuron datapath across NUM_NEURONS neurons of
//   a fully connected layer. A layer start latches the 64-bit input vector.
//   Then, for each neuron index, the block presents the index to the
//   weight/bias store, pulses neuron_start, and waits for a rising edge on
//   neuron_finish. It then writes the 8-bit result into the layer output
//   buffer. A watchdog aborts the layer if a neuron never finishes.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   start, layer_inp    layer request (sampled in IDLE) and 8x8-bit inputs
//   busy, done, error   status: not idle / end-of-layer pulse / sticky timeout
//   neuron_idx          current neuron, addresses the weight/bias store
//   neuron_start        one-cycle start pulse to the neuron
//   neuron_inp          layer input latched at start acceptance
//   neuron_finish/out   neuron completion (level or pulse) and its result
//   res_we/addr/data    result buffer write port
module neuron_layer_scheduler #(
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      layer_inp,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] neuron_idx,
  output logic             neuron_start,
  output logic [63:0]      neuron_inp,
  input  logic             neuron_finish,
  input  logic [7:0]       neuron_out,
  output logic             res_we,
  output logic [IDX_W-1:0] res_addr,
  output logic [7:0]       res_data
);

  // The watchdog must be able to hold the value TIMEOUT.
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [63:0]      inp_q, inp_d;
  logic             err_q, err_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             fin_prev_q, fin_prev_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             nstart_q, nstart_d;
  logic             we_q, we_d;
  logic             fin_rise;

  // Only a fresh rising edge counts as completion. A finish level still high
  // from the previous neuron must not complete the current one.
  assign fin_rise = neuron_finish & ~fin_prev_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    inp_d      = inp_q;
    err_d      = err_q;
    wd_d       = wd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    fin_prev_d = neuron_finish;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          inp_d   = layer_inp;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fin_rise) begin
          data_d  = neuron_out;
          addr_d  = idx_q;
          state_d = S_STORE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th WAIT cycle without completion.
          // Abort the layer; no write is made for this neuron.
          wd_d    = wd_q + WD_W'(1);
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_STORE: begin
        if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state and then registered. Each
    // output is therefore a clean flop that is valid for the whole cycle
    // the FSM spends in that state.
    busy_d   = (state_d != S_IDLE);
    nstart_d = (state_d == S_ISSUE);
    we_d     = (state_d == S_STORE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      inp_q      <= '0;
      err_q      <= 1'b0;
      wd_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      fin_prev_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nstart_q   <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      inp_q      <= inp_d;
      err_q      <= err_d;
      wd_q       <= wd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      fin_prev_q <= fin_prev_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nstart_q   <= nstart_d;
      we_q       <= we_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
  assign neuron_idx   = idx_q;
  assign neuron_start = nstart_q;
  assign neuron_inp   = inp_q;
  assign res_we       = we_q;
  assign res_addr     = addr_q;
  assign res_data     = data_q;

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
module tb_neuron_layer_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 8 neurons, TIMEOUT=10
  logic        start_a = 1'b0;
  logic [63:0] inp_a = '0;
  logic        busy_a, done_a, err_a, ns_a, we_a;
  logic [2:0]  idx_a, addr_a;
  logic [63:0] ninp_a;
  logic [7:0]  data_a;
  logic        fin_a = 1'b0;
  logic [7:0]  nout_a = '0;

  // Instance B: 1 neuron
  logic        start_b = 1'b0;
  logic        busy_b, done_b, err_b, ns_b, we_b;
  logic [0:0]  idx_b, addr_b;
  logic [63:0] ninp_b;
  logic [7:0]  data_b;
  logic        fin_b = 1'b0;
  logic [7:0]  nout_b;
  assign nout_b = 8'hA5;

  neuron_layer_scheduler #(.NUM_NEURONS(8), .IDX_W(3), .TIMEOUT(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .layer_inp(inp_a),
    .busy(busy_a), .done(done_a), .error(err_a), .neuron_idx(idx_a),
    .neuron_start(ns_a), .neuron_inp(ninp_a), .neuron_finish(fin_a),
    .neuron_out(nout_a), .res_we(we_a), .res_addr(addr_a), .res_data(data_a)
  );

  neuron_layer_scheduler #(.NUM_NEURONS(1), .IDX_W(1), .TIMEOUT(10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .layer_inp(64'hCAFE),
    .busy(busy_b), .done(done_b), .error(err_b), .neuron_idx(idx_b),
    .neuron_start(ns_b), .neuron_inp(ninp_b), .neuron_finish(fin_b),
    .neuron_out(nout_b), .res_we(we_b), .res_addr(addr_b), .res_data(data_b)
  );

  // Neuron model A. Finish rises 4 cycles after neuron_start is seen, so WAIT
  // lasts 4 cycles. out = 3*idx+1, registered at the rise.
  // mode 0: one-cycle pulse
  // mode 1: level held until one cycle into the next neuron's WAIT
  // mode 2: like mode 0, but neuron 2 never finishes
  int         mode_a = 0;
  logic [3:0] sr_a = '0;
  always @(posedge clk) begin
    sr_a <= {sr_a[2:0], ns_a};
    if (sr_a[2] === 1'b1 && !(mode_a == 2 && idx_a == 3'd2)) begin
      fin_a  <= 1'b1;
      nout_a <= 8'(idx_a) * 8'd3 + 8'd1;
    end else if (mode_a != 1 || sr_a[0] === 1'b1) begin
      fin_a <= 1'b0;
    end
  end

  // Neuron model B finishes in the first WAIT cycle.
  always @(posedge clk) fin_b <= (ns_b === 1'b1);

  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/done log for instance A, with cycle numbers relative to the start.
  int wr_cnt = 0, done_cnt = 0;
  int wr_addr [32];
  int wr_data [32];
  int wr_rel  [32];
  int done_rel [8];
  always @(posedge clk) begin
    #1;
    if (we_a === 1'b1 && wr_cnt < 32) begin
      wr_addr[wr_cnt] = int'(addr_a);
      wr_data[wr_cnt] = int'(data_a);
      wr_rel[wr_cnt]  = cyc - t0;
      wr_cnt++;
    end
    if (done_a === 1'b1 && done_cnt < 8) begin
      done_rel[done_cnt] = cyc - t0;
      done_cnt++;
    end
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_rel(input int r);
    while (cyc - t0 < r) @(negedge clk);
  endtask

  // Pulse start for one cycle on instance A; rel 0 is this negedge.
  task automatic go_a(input logic [63:0] v);
    start_a = 1'b1;
    inp_a = v;
    t0 = cyc;
    wr_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  localparam logic [63:0] VA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] VB = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] VC = 64'h1111_2222_3333_4444;
  localparam logic [63:0] VD = 64'hDEAD_BEEF_0BAD_F00D;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_nstart", ns_a, 0);
    check("rst_we", we_a, 0);
    check("rst_idx", idx_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_data", data_a, 0);
    check("rst_ninp", ninp_a, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    // Full layer with pulsed finish, plus a start pulse mid-layer that must
    // be ignored
    mode_a = 0;
    go_a(VA);
    check("full_issue_ns", ns_a, 1);
    check("full_issue_idx", idx_a, 0);
    check("full_issue_busy", busy_a, 1);
    check("full_ninp", ninp_a, VA);
    to_rel(20);
    start_a = 1'b1;
    inp_a = VB;
    @(negedge clk);
    start_a = 1'b0;
    check("mid_start_idx", idx_a, 3);
    check("mid_start_ninp", ninp_a, VA);
    to_rel(49);
    check("full_done", done_a, 1);
    check("full_done_busy", busy_a, 1);
    to_rel(50);
    check("full_idle_busy", busy_a, 0);
    check("full_idle_done", done_a, 0);
    to_rel(60);
    check("full_wr_cnt", wr_cnt, 8);
    check("full_done_cnt", done_cnt, 1);
    check("full_done_rel", done_rel[0], 49);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_addr%0d", i), wr_addr[i], i);
      check($sformatf("full_data%0d", i), wr_data[i], 3 * i + 1);
      check($sformatf("full_rel%0d", i), wr_rel[i], 6 * (i + 1));
    end

    // Level-held finish: each write must still be fresh and on time
    mode_a = 1;
    go_a(VC);
    to_rel(60);
    check("lvl_wr_cnt", wr_cnt, 8);
    check("lvl_done_rel", done_rel[0], 49);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lvl_data%0d", i), wr_data[i], 3 * i + 1);
      check($sformatf("lvl_rel%0d", i), wr_rel[i], 6 * (i + 1));
    end

    // Timeout on neuron 2: ISSUE at rel 13, WAIT at rel 14..23, DONE at rel 24
    mode_a = 2;
    go_a(VA);
    to_rel(23);
    check("to_pre_done", done_a, 0);
    check("to_pre_err", err_a, 0);
    to_rel(24);
    check("to_done", done_a, 1);
    check("to_err", err_a, 1);
    to_rel(25);
    check("to_idle_busy", busy_a, 0);
    to_rel(30);
    check("to_err_sticky", err_a, 1);
    check("to_wr_cnt", wr_cnt, 2);
    check("to_wr1_addr", wr_addr[1], 1);
    check("to_done_rel", done_rel[0], 24);

    // Next start clears error; then reset in the middle of WAIT at idx 3
    mode_a = 0;
    go_a(VD);
    check("clr_err", err_a, 0);
    to_rel(21);
    check("pre_rst_idx", idx_a, 3);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_idx", idx_a, 0);
    check("mid_rst_ninp", ninp_a, 0);
    check("mid_rst_data", data_a, 0);
    check("mid_rst_addr", addr_a, 0);
    check("mid_rst_we", we_a, 0);
    check("mid_rst_ns", ns_a, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_wr_cnt", wr_cnt, 3);
    check("post_rst_done_cnt", done_cnt, 0);
    check("post_rst_busy", busy_a, 0);

    // start held high: back-to-back layers separated by one IDLE cycle
    start_a = 1'b1;
    inp_a = VA;
    t0 = cyc;
    wr_cnt = 0;
    done_cnt = 0;
    to_rel(20);
    check("b2b_ninp1", ninp_a, VA);
    inp_a = VB;
    to_rel(49);
    check("b2b_done1", done_a, 1);
    to_rel(50);
    check("b2b_idle_busy", busy_a, 0);
    to_rel(51);
    check("b2b_issue2_ns", ns_a, 1);
    check("b2b_issue2_idx", idx_a, 0);
    check("b2b_ninp2", ninp_a, VB);
    inp_a = VC;
    to_rel(60);
    start_a = 1'b0;
    check("b2b_ninp2_stable", ninp_a, VB);
    to_rel(105);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_done_rel1", done_rel[1], 99);
    check("b2b_wr_cnt", wr_cnt, 16);
    check("b2b_wr8_rel", wr_rel[8], 56);
    check("b2b_wr8_data", wr_data[8], 1);

    // Single-neuron layer, finish in the first WAIT cycle
    start_b = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_b = 1'b0;
    check("one_issue_ns", ns_b, 1);
    check("one_issue_busy", busy_b, 1);
    to_rel(2);
    check("one_wait_we", we_b, 0);
    check("one_wait_busy", busy_b, 1);
    to_rel(3);
    check("one_store_we", we_b, 1);
    check("one_store_addr", addr_b, 0);
    check("one_store_data", data_b, 8'hA5);
    to_rel(4);
    check("one_done", done_b, 1);
    check("one_done_we", we_b, 0);
    to_rel(5);
    check("one_idle_busy", busy_b, 0);
    check("one_idle_done", done_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
